// File: rtl/inst_encode_if.sv
// Stream + instruction-memory bus for inst_encode_loader.
// master: tuple producer / imem observer; slave: the loader itself.
interface inst_encode_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/inst_encode_loader.sv
// inst_encode_loader: encodes ADD/LW/ADDI/SW/LUI tuples into RV32I words and
// writes them sequentially into instruction memory, one write per accepted
// legal tuple, one cycle after acceptance.
// Optional feature macro: INST_ENC_IMM_CHECK_EN (immediate range checking,
// drives err_imm). Without it err_imm is constant 0.
module inst_encode_loader #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
    parameter int                DEPTH     = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    inst_encode_if.slave               bus,
    output logic [$clog2(DEPTH+1)-1:0] words_written,
    output logic                       done,
    output logic                       err_op,
    output logic                       err_imm
);
    localparam int                CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ONE_CNT   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(3'd4);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_LW   = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_LUI  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             op_valid;
    logic             imm_valid;
    logic             do_write;
    logic             finish;
    logic [CNT_W-1:0] issued;
    logic [31:0]      enc_word;

    // RV32I word for one tuple; illegal ops encode to zero (never written).
    function automatic logic [31:0] encode(
        input logic [2:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] word;
        case (op)
            OP_ADD:  word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            OP_LW:   word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            OP_ADDI: word = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            OP_SW:   word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            OP_LUI:  word = {imm[31:12], rd, 7'b0110111};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

`ifdef INST_ENC_IMM_CHECK_EN
    // I/S immediates must sign-extend from bit 11; LUI must have a clean low 12 bits.
    function automatic logic imm_fits(input logic [2:0] op, input logic [31:0] imm);
        logic ok;
        case (op)
            OP_LW, OP_ADDI, OP_SW: ok = (&imm[31:11]) | ~(|imm[31:11]);
            OP_LUI:                ok = (imm[11:0] == 12'h000);
            default:               ok = 1'b1;
        endcase
        return ok;
    endfunction
`endif

    // Ready only while loading and not being restarted this cycle.
    assign bus.in_ready = (state == S_LOAD) && !start;

    // Accept/legality decode and next-state selection.
    always_comb begin
        state_next = state;
        accept     = bus.in_valid && bus.in_ready;
        op_valid   = (bus.in_op <= OP_LUI);
`ifdef INST_ENC_IMM_CHECK_EN
        imm_valid  = imm_fits(bus.in_op, bus.in_imm);
`else
        imm_valid  = 1'b1;
`endif
        do_write   = accept && op_valid && imm_valid;
        enc_word   = encode(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
        // Words already committed to imem plus the one currently in flight.
        issued     = words_written + {{(CNT_W-1){1'b0}}, bus.imem_we};
        finish     = accept && (bus.in_last || (do_write && ((issued + ONE_CNT) == DEPTH_CNT)));
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LOAD;
                else       state_next = S_IDLE;
            end
            S_LOAD: begin
                if (start)       state_next = S_LOAD;
                else if (finish) state_next = S_DONE;
                else             state_next = S_LOAD;
            end
            S_DONE: begin
                if (start) state_next = S_LOAD;
                else       state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Write port, address/count bookkeeping, done and err_op flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= BASE_ADDR;
            bus.imem_wdata <= 32'h0000_0000;
            words_written  <= {CNT_W{1'b0}};
            done           <= 1'b0;
            err_op         <= 1'b0;
        end else begin
            bus.imem_we <= do_write;
            if (do_write) bus.imem_wdata <= enc_word;
            if (start) begin
                // (Re)entering LOAD; an in-flight write still lands this edge.
                bus.imem_addr <= BASE_ADDR;
                words_written <= {CNT_W{1'b0}};
                done          <= 1'b0;
                err_op        <= 1'b0;
            end else begin
                if (bus.imem_we) begin
                    bus.imem_addr <= bus.imem_addr + ADDR_STEP;
                    words_written <= words_written + ONE_CNT;
                end
                if (accept && !op_valid) err_op <= 1'b1;
                // A finishing tuple with no write ends immediately; otherwise
                // done follows the final write cycle.
                done <= (state == S_DONE) || (finish && !do_write);
            end
        end
    end

`ifdef INST_ENC_IMM_CHECK_EN
    // Sticky out-of-range immediate flag, cleared on (re)start.
    always_ff @(posedge clk) begin
        if (rst)                                    err_imm <= 1'b0;
        else if (start)                             err_imm <= 1'b0;
        else if (accept && op_valid && !imm_valid)  err_imm <= 1'b1;
        else                                        err_imm <= err_imm;
    end
`else
    assign err_imm = 1'b0;
`endif
endmodule

// File: tb/tb_inst_encode_loader.sv
// Self-checking bench for inst_encode_loader: directed spec scenarios plus a
// randomized stream checked against an arithmetic encoding model.
`timescale 1ns/1ps
module tb_inst_encode_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 256;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] words_written;
    logic             done;
    logic             err_op;
    logic             err_imm;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];

    inst_encode_if #(.ADDR_W(ADDR_W)) bus();

    inst_encode_loader #(
        .ADDR_W(ADDR_W),
        .BASE_ADDR(10'h000),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus),
        .words_written(words_written),
        .done(done),
        .err_op(err_op),
        .err_imm(err_imm)
    );

    always #5 clk = ~clk;

    // Record every imem write, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr_q.push_back(bus.imem_addr);
            wr_data_q.push_back(bus.imem_wdata);
        end
    end

    // Reference encoding built from field positions with plain arithmetic.
    function automatic logic [31:0] ref_encode(input int op, input int rd, input int rs1,
                                               input int rs2, input logic [31:0] imm);
        logic [31:0] r;
        logic [31:0] lo12;
        lo12 = imm & 32'h0000_0FFF;
        case (op)
            0: r = rs2 * 32'd1048576 + rs1 * 32'd32768 + rd * 32'd128 + 32'd51;
            1: r = lo12 * 32'd1048576 + rs1 * 32'd32768 + 32'd8192 + rd * 32'd128 + 32'd3;
            2: r = lo12 * 32'd1048576 + rs1 * 32'd32768 + rd * 32'd128 + 32'd19;
            3: r = ((lo12 / 32'd32) * 32'd33554432) + rs2 * 32'd1048576 + rs1 * 32'd32768
                   + 32'd8192 + (lo12 % 32'd32) * 32'd128 + 32'd35;
            4: r = (imm & 32'hFFFF_F000) + rd * 32'd128 + 32'd55;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Whether a tuple produces a write.
    function automatic bit ref_legal(input int op, input logic [31:0] imm);
        bit chk;
        chk = 1'b0;
`ifdef INST_ENC_IMM_CHECK_EN
        chk = 1'b1;
`endif
        if (op > 4) return 1'b0;
        if (!chk || op == 0) return 1'b1;
        if (op == 4) return (imm % 32'd4096) == 32'd0;
        return ($signed(imm) >= -2048) && ($signed(imm) <= 2047);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_op    = 3'd0;
        bus.in_rd    = 5'd0;
        bus.in_rs1   = 5'd0;
        bus.in_rs2   = 5'd0;
        bus.in_imm   = 32'd0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drive(input int op, input int rd, input int rs1, input int rs2,
                         input logic [31:0] imm, input bit last);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'(op);
        bus.in_rd    = 5'(rd);
        bus.in_rs1   = 5'(rs1);
        bus.in_rs2   = 5'(rs2);
        bus.in_imm   = imm;
        bus.in_last  = last;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset();
        logic [55:0] got;
        rst = 1'b1;
        start = 1'b0;
        idle_inputs();
        step();
        step();
        got = {bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, words_written, done, err_op, err_imm};
        n_cmp++;
        if (got !== 56'h0) begin n_fail++; $display("FAIL reset_state: got %h want %h", got, 56'h0); end
        rst = 1'b0;
        clear_log();
        drive(2, 1, 0, 0, 32'd5, 1'b0);
        step(); step(); step();
        n_cmp++;
        if (wr_addr_q.size() != 0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL idle_ignored: writes %0d ready %b want 0 0", wr_addr_q.size(), bus.in_ready);
        end
        idle_inputs();
    endtask

    task automatic test_addi();
        pulse_start();
        drive(2, 1, 0, 0, 32'd5, 1'b0);
        step();
        n_cmp++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 10'h000, 32'h00500093}) begin
            n_fail++; $display("FAIL addi_write: got we=%b addr=%h data=%h want 1 000 00500093",
                               bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
        idle_inputs();
        step();
        n_cmp++;
        if ({bus.imem_we, bus.imem_addr, words_written} !== {1'b0, 10'h004, 9'd1}) begin
            n_fail++; $display("FAIL addi_after: got we=%b addr=%h ww=%0d want 0 004 1",
                               bus.imem_we, bus.imem_addr, words_written);
        end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        drive(0, 3, 1, 2, 32'd0, 1'b0);
        step();
        n_cmp++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 10'h000, 32'h002081B3}) begin
            n_fail++; $display("FAIL b2b_add: got we=%b addr=%h data=%h want 1 000 002081b3",
                               bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
        drive(1, 5, 2, 0, 32'd8, 1'b0);
        step();
        n_cmp++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 10'h004, 32'h00812283}) begin
            n_fail++; $display("FAIL b2b_lw: got we=%b addr=%h data=%h want 1 004 00812283",
                               bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_sw_lui_last();
        pulse_start();
        drive(3, 0, 2, 5, 32'd12, 1'b0);
        step();
        n_cmp++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 10'h000, 32'h00512623}) begin
            n_fail++; $display("FAIL sw_write: got we=%b addr=%h data=%h want 1 000 00512623",
                               bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
        drive(4, 7, 0, 0, 32'h12345000, 1'b1);
        step();
        n_cmp++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata, done} !== {1'b1, 10'h004, 32'h123453B7, 1'b0}) begin
            n_fail++; $display("FAIL lui_write: got we=%b addr=%h data=%h done=%b want 1 004 123453b7 0",
                               bus.imem_we, bus.imem_addr, bus.imem_wdata, done);
        end
        idle_inputs();
        step();
        n_cmp++;
        if ({done, words_written, bus.in_ready} !== {1'b1, 9'd2, 1'b0}) begin
            n_fail++; $display("FAIL last_done: got done=%b ww=%0d ready=%b want 1 2 0",
                               done, words_written, bus.in_ready);
        end
        drive(2, 1, 0, 0, 32'd1, 1'b0);
        step();
        n_cmp++;
        if ({bus.imem_we, done, words_written} !== {1'b0, 1'b1, 9'd2}) begin
            n_fail++; $display("FAIL done_ignores: got we=%b done=%b ww=%0d want 0 1 2",
                               bus.imem_we, done, words_written);
        end
        idle_inputs();
    endtask

    task automatic test_invalid_op();
        logic [31:0] exp;
        pulse_start();
        drive(2, 1, 0, 0, 32'd5, 1'b0);
        step();
        drive(6, 4, 4, 4, 32'd9, 1'b0);
        step();
        n_cmp++;
        if ({bus.imem_we, err_op} !== 2'b01) begin
            n_fail++; $display("FAIL invalid_op: got we=%b err_op=%b want 0 1", bus.imem_we, err_op);
        end
        drive(2, 2, 1, 0, 32'hFFFF_FFFF, 1'b0);
        exp = ref_encode(2, 2, 1, 0, 32'hFFFF_FFFF);
        step();
        n_cmp++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 10'h004, exp}) begin
            n_fail++; $display("FAIL after_invalid: got we=%b addr=%h data=%h want 1 004 %h",
                               bus.imem_we, bus.imem_addr, bus.imem_wdata, exp);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_restart();
        clear_log();
        drive(2, 8, 0, 0, 32'd3, 1'b0);
        step();
        n_cmp++;
        if (err_op !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_op); end
        pulse_start();
        n_cmp++;
        if ({bus.imem_we, bus.imem_addr, words_written, err_op, done} !== {1'b0, 10'h000, 9'd0, 1'b0, 1'b0}
            || wr_addr_q.size() != 1) begin
            n_fail++; $display("FAIL restart: got we=%b addr=%h ww=%0d err=%b done=%b writes=%0d want 0 000 0 0 0 1",
                               bus.imem_we, bus.imem_addr, words_written, err_op, done, wr_addr_q.size());
        end
        drive(2, 9, 0, 0, 32'd7, 1'b0);
        step();
        n_cmp++;
        if ({bus.imem_we, bus.imem_addr} !== {1'b1, 10'h000}) begin
            n_fail++; $display("FAIL restart_addr: got we=%b addr=%h want 1 000", bus.imem_we, bus.imem_addr);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_imm_range();
        pulse_start();
        drive(2, 0, 0, 0, 32'h0000_0800, 1'b0);
        step();
`ifdef INST_ENC_IMM_CHECK_EN
        n_cmp++;
        if ({bus.imem_we, err_imm} !== 2'b01) begin
            n_fail++; $display("FAIL imm_check: got we=%b err_imm=%b want 0 1", bus.imem_we, err_imm);
        end
`else
        n_cmp++;
        if ({bus.imem_we, bus.imem_wdata, err_imm} !== {1'b1, 32'h80000013, 1'b0}) begin
            n_fail++; $display("FAIL imm_nocheck: got we=%b data=%h err_imm=%b want 1 80000013 0",
                               bus.imem_we, bus.imem_wdata, err_imm);
        end
`endif
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        logic [31:0] exp_data[$];
        int          exp_cnt;
        bit          exp_err_op;
        bit          exp_err_imm;
        int          op;
        int          t;
        logic [31:0] imm;
        exp_cnt = 0;
        exp_err_op = 1'b0;
        exp_err_imm = 1'b0;
        pulse_start();
        clear_log();
        for (int i = 0; i < 40; i++) begin
            t = $urandom_range(0, 2);
            for (int g = 0; g < t; g++) step();
            op = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            case ($urandom_range(0, 2))
                0: imm = $urandom;
                1: begin t = $urandom_range(0, 4095); imm = 32'(t - ((t >= 2048) ? 4096 : 0)); end
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            drive(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm, i == 39);
            if (ref_legal(op, imm)) begin
                exp_data.push_back(ref_encode(op, bus.in_rd, bus.in_rs1, bus.in_rs2, imm));
                exp_cnt++;
            end else if (op > 4) begin
                exp_err_op = 1'b1;
            end else begin
                exp_err_imm = 1'b1;
            end
            step();
            idle_inputs();
        end
        step();
        step();
        n_cmp++;
        if (wr_addr_q.size() != exp_cnt) begin
            n_fail++; $display("FAIL rand_count: got %0d writes want %0d", wr_addr_q.size(), exp_cnt);
        end
        for (int k = 0; k < exp_cnt && k < wr_addr_q.size(); k++) begin
            n_cmp++;
            if (wr_addr_q[k] !== 10'(4 * k) || wr_data_q[k] !== exp_data[k]) begin
                n_fail++; $display("FAIL rand_write[%0d]: got %h@%h want %h@%h",
                                   k, wr_data_q[k], wr_addr_q[k], exp_data[k], 10'(4 * k));
            end
        end
        n_cmp++;
        if ({done, words_written, err_op, err_imm} !== {1'b1, 9'(exp_cnt), exp_err_op, exp_err_imm}) begin
            n_fail++; $display("FAIL rand_status: got done=%b ww=%0d err_op=%b err_imm=%b want 1 %0d %b %b",
                               done, words_written, err_op, err_imm, exp_cnt, exp_err_op, exp_err_imm);
        end
    endtask

    task automatic test_depth();
        logic [31:0] exp_last;
        pulse_start();
        clear_log();
        for (int i = 0; i < DEPTH; i++) begin
            drive(2, i % 32, 0, 0, 32'(i), 1'b0);
            step();
        end
        n_cmp++;
        if ({bus.imem_we, done} !== 2'b10) begin
            n_fail++; $display("FAIL depth_inflight: got we=%b done=%b want 1 0", bus.imem_we, done);
        end
        step();
        n_cmp++;
        if ({done, words_written, bus.in_ready} !== {1'b1, 9'(DEPTH), 1'b0}) begin
            n_fail++; $display("FAIL depth_done: got done=%b ww=%0d ready=%b want 1 %0d 0",
                               done, words_written, bus.in_ready, DEPTH);
        end
        step();
        idle_inputs();
        exp_last = ref_encode(2, (DEPTH - 1) % 32, 0, 0, 32'(DEPTH - 1));
        n_cmp++;
        if (wr_addr_q.size() != DEPTH) begin
            n_fail++; $display("FAIL depth_count: got %0d writes want %0d", wr_addr_q.size(), DEPTH);
        end else if (wr_addr_q[DEPTH-1] !== 10'h3FC || wr_data_q[DEPTH-1] !== exp_last) begin
            n_fail++; $display("FAIL depth_last: got %h@%h want %h@3fc",
                               wr_data_q[DEPTH-1], wr_addr_q[DEPTH-1], exp_last);
        end
    endtask

    task automatic test_rst_mid_load();
        logic [55:0] got;
        pulse_start();
        drive(2, 1, 0, 0, 32'd5, 1'b0);
        step();
        drive(7, 1, 1, 1, 32'd0, 1'b0);
        step();
        drive(0, 1, 2, 3, 32'd0, 1'b0);
        rst = 1'b1;
        step();
        got = {bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, words_written, done, err_op, err_imm};
        n_cmp++;
        if (got !== 56'h0) begin n_fail++; $display("FAIL rst_mid_load: got %h want %h", got, 56'h0); end
        rst = 1'b0;
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_sw_lui_last();
        test_invalid_op();
        test_restart();
        test_imm_range();
        test_random();
        test_depth();
        test_rst_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
